axi4_ram_target: RTL and testbench

- AXI4 burst responder backed by an internal byte-enabled RAM.
- It is the target end of the AXI4 initiator interface that the debug bridge and the CPU TCM wrapper drive: awid/awlen/awburst, wlast, bid, rid and rlast.
- It serves as a scratch/trace memory on the debug AXI path, and as a bench responder for initiator blocks.
- It handles one transaction at a time, with alternating read/write priority.

---
 rtl/axi4_target_defs.sv | 42 ++++
 rtl/axi4_ram_target_mem.sv | 25 ++
 rtl/axi4_ram_target.sv | 223 ++++++++++++++++++++++
 tb/tb_axi4_ram_target.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_target_defs.sv
// rtl/axi4_target_defs.sv - shared codes, states and address stepping for the AXI4 RAM target (optional AXI4_RAM_TARGET_WRAP_EN)
package axi4_target_defs;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef AXI4_RAM_TARGET_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_WRESP = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  // WRAP bursts must span a power-of-two number of beats between 2 and 16
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Word address of the following beat; callers truncate to the RAM width,
  // which makes INCR roll over inside the window
  function automatic logic [31:0] next_word(input logic [1:0]  burst,
                                            input logic [7:0]  len,
                                            input logic [31:0] word);
    logic [31:0] mask;
    mask = {24'd0, len};
    if (burst == BURST_FIXED) return word;
    if (WRAP_EN && (burst == BURST_WRAP)) return (word & ~mask) | ((word + 32'd1) & mask);
    return word + 32'd1;
  endfunction

endpackage

// File: rtl/axi4_ram_target_mem.sv
// rtl/axi4_ram_target_mem.sv - single-port byte-enabled synchronous RAM, one-cycle read latency
module axi4_ram_target_mem #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Byte-lane writes and registered read of the addressed word
  always_ff @(posedge clk_i) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axi4_ram_target.sv
// rtl/axi4_ram_target.sv - AXI4 burst target over internal RAM (optional AXI4_RAM_TARGET_WRAP_EN)
module axi4_ram_target
  import axi4_target_defs::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        axi_awvalid_i,
  output logic        axi_awready_o,
  input  logic [31:0] axi_awaddr_i,
  input  logic [3:0]  axi_awid_i,
  input  logic [7:0]  axi_awlen_i,
  input  logic [1:0]  axi_awburst_i,
  input  logic        axi_wvalid_i,
  output logic        axi_wready_o,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  input  logic        axi_wlast_i,
  output logic        axi_bvalid_o,
  input  logic        axi_bready_i,
  output logic [1:0]  axi_bresp_o,
  output logic [3:0]  axi_bid_o,
  input  logic        axi_arvalid_i,
  output logic        axi_arready_o,
  input  logic [31:0] axi_araddr_i,
  input  logic [3:0]  axi_arid_i,
  input  logic [7:0]  axi_arlen_i,
  input  logic [1:0]  axi_arburst_i,
  output logic        axi_rvalid_o,
  input  logic        axi_rready_i,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic [3:0]  axi_rid_o,
  output logic        axi_rlast_o
);

  state_t            state_q, state_d;
  logic              prio_wr_q;
  logic [3:0]        id_q;
  logic [7:0]        len_q;
  logic [1:0]        burst_q;
  logic [1:0]        resp_q;
  logic [ADDR_W-1:0] word_q;
  logic [8:0]        beat_q;

  logic              rd_pend_q, rd_pend_last_q;
  logic [1:0]        cnt_q;
  logic [31:0]       buf0_data_q, buf1_data_q;
  logic              buf0_last_q, buf1_last_q;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [31:0]       mem_rdata;

  logic              aw_hs, ar_hs, w_hs, r_pop, rd_issue, last_beat;
  logic [2:0]        occ;
  logic [31:0]       hs_addr, push_data;
  logic [7:0]        hs_len;
  logic [1:0]        hs_burst;
  logic [3:0]        hs_id;
  logic              unused_bits;

  assign aw_hs     = axi_awvalid_i & axi_awready_o;
  assign ar_hs     = axi_arvalid_i & axi_arready_o;
  assign w_hs      = axi_wvalid_i & axi_wready_o;
  assign r_pop     = axi_rvalid_o & axi_rready_i;
  assign last_beat = (beat_q == {1'b0, len_q});

  assign hs_addr  = aw_hs ? axi_awaddr_i  : axi_araddr_i;
  assign hs_len   = aw_hs ? axi_awlen_i   : axi_arlen_i;
  assign hs_burst = aw_hs ? axi_awburst_i : axi_arburst_i;
  assign hs_id    = aw_hs ? axi_awid_i    : axi_arid_i;

  // Slots the output buffer will hold once the read in flight lands; a new
  // read is issued only if it is guaranteed a slot
  assign occ       = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, r_pop};
  assign push_data = (resp_q == RESP_OKAY) ? mem_rdata : 32'd0;

  assign axi_rvalid_o = (cnt_q != 2'd0);
  assign axi_rdata_o  = buf0_data_q;
  assign axi_rlast_o  = axi_rvalid_o & buf0_last_q;
  assign axi_rid_o    = id_q;
  assign axi_rresp_o  = resp_q;
  assign axi_bid_o    = id_q;
  assign axi_bresp_o  = resp_q;

  assign unused_bits = ^{axi_wlast_i, hs_addr[1:0]};

  // Window decode on the start address, plus illegal WRAP lengths when WRAP is enabled
  function automatic logic [1:0] decode(input logic [31:0] a, input logic [1:0] b,
                                        input logic [7:0] l);
    if (a[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]) return RESP_DECERR;
    if (WRAP_EN && (b == BURST_WRAP) && !wrap_len_ok(l)) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, handshake readies and RAM port control
  always_comb begin
    state_d       = state_q;
    axi_awready_o = 1'b0;
    axi_arready_o = 1'b0;
    axi_wready_o  = 1'b0;
    axi_bvalid_o  = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 4'h0;
    rd_issue      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        axi_awready_o = rst_i & axi_awvalid_i & (~axi_arvalid_i | prio_wr_q);
        axi_arready_o = rst_i & axi_arvalid_i & (~axi_awvalid_i | ~prio_wr_q);
        if (axi_awready_o)      state_d = ST_WDATA;
        else if (axi_arready_o) state_d = ST_RDATA;
      end
      ST_WDATA: begin
        axi_wready_o = 1'b1;
        if (axi_wvalid_i) begin
          mem_en = 1'b1;
          if (resp_q == RESP_OKAY) mem_we = axi_wstrb_i;
          if (last_beat) state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        axi_bvalid_o = 1'b1;
        if (axi_bready_i) state_d = ST_IDLE;
      end
      ST_RDATA: begin
        if ((beat_q <= {1'b0, len_q}) && (occ <= 3'd1)) begin
          rd_issue = 1'b1;
          mem_en   = 1'b1;
        end
        if (r_pop && buf0_last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction context: latched on address handshake, stepped per data beat
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      prio_wr_q <= 1'b1;
      id_q      <= 4'h0;
      len_q     <= 8'h0;
      burst_q   <= 2'b00;
      resp_q    <= RESP_OKAY;
      word_q    <= '0;
      beat_q    <= 9'd0;
    end else if (aw_hs || ar_hs) begin
      prio_wr_q <= ar_hs;
      id_q      <= hs_id;
      len_q     <= hs_len;
      burst_q   <= hs_burst;
      resp_q    <= decode(hs_addr, hs_burst, hs_len);
      word_q    <= hs_addr[ADDR_W+1:2];
      beat_q    <= 9'd0;
    end else if (w_hs || rd_issue) begin
      word_q <= (ADDR_W)'(next_word(burst_q, len_q, 32'(word_q)));
      beat_q <= beat_q + 9'd1;
    end
  end

  // Read prefetch landing and two-entry output buffer; head holds still while stalled
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
      cnt_q          <= 2'd0;
      buf0_data_q    <= 32'd0;
      buf1_data_q    <= 32'd0;
      buf0_last_q    <= 1'b0;
      buf1_last_q    <= 1'b0;
    end else begin
      rd_pend_q      <= rd_issue;
      rd_pend_last_q <= rd_issue & last_beat;
      case ({rd_pend_q, r_pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            buf0_data_q <= push_data;
            buf0_last_q <= rd_pend_last_q;
          end else begin
            buf1_data_q <= push_data;
            buf1_last_q <= rd_pend_last_q;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          buf0_data_q <= buf1_data_q;
          buf0_last_q <= buf1_last_q;
          cnt_q       <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            buf0_data_q <= push_data;
            buf0_last_q <= rd_pend_last_q;
          end else begin
            buf0_data_q <= buf1_data_q;
            buf0_last_q <= buf1_last_q;
            buf1_data_q <= push_data;
            buf1_last_q <= rd_pend_last_q;
          end
        end
        default: ;
      endcase
    end
  end

  axi4_ram_target_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk_i (clk_i),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (word_q),
    .wdata (axi_wdata_i),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_axi4_ram_target.sv
// tb/tb_axi4_ram_target.sv - directed self-checking bench for axi4_ram_target (AXI4_RAM_TARGET_WRAP_EN optional)
module tb_axi4_ram_target;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awid, arid, wstrb, bid, rid;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] wbuf [16];
  logic [31:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  logic [3:0]  rd_id;
  int          rd_first, rd_cycles;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  always #5 clk_i = ~clk_i;

  axi4_ram_target dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .axi_awvalid_i(awvalid), .axi_awready_o(awready), .axi_awaddr_i(awaddr),
    .axi_awid_i(awid), .axi_awlen_i(awlen), .axi_awburst_i(awburst),
    .axi_wvalid_i(wvalid), .axi_wready_o(wready), .axi_wdata_i(wdata),
    .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
    .axi_bvalid_o(bvalid), .axi_bready_i(bready), .axi_bresp_o(bresp), .axi_bid_o(bid),
    .axi_arvalid_i(arvalid), .axi_arready_o(arready), .axi_araddr_i(araddr),
    .axi_arid_i(arid), .axi_arlen_i(arlen), .axi_arburst_i(arburst),
    .axi_rvalid_o(rvalid), .axi_rready_i(rready), .axi_rdata_o(rdata),
    .axi_rresp_o(rresp), .axi_rid_o(rid), .axi_rlast_o(rlast)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] strb);
    int t;
    @(negedge clk_i);
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awburst = burst;
    t = 0; #1;
    while (!awready && t < 50) begin @(negedge clk_i); #1; t++; end
    check("aw_accept", 32'(t < 50), 1);
    @(posedge clk_i); @(negedge clk_i);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = strb; wlast = (i == int'(len));
      t = 0; #1;
      while (!wready && t < 50) begin @(negedge clk_i); #1; t++; end
      @(posedge clk_i); @(negedge clk_i);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    #1;
    check("b_after_last_beat", 32'(bvalid), 1);
    b_resp = bresp; b_id = bid;
    @(posedge clk_i); @(negedge clk_i);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input bit toggle);
    int t, n, first;
    logic held;
    logic [31:0] hd;
    @(negedge clk_i);
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arburst = burst;
    t = 0; #1;
    while (!arready && t < 50) begin @(negedge clk_i); #1; t++; end
    check("ar_accept", 32'(t < 50), 1);
    @(posedge clk_i); @(negedge clk_i);
    arvalid = 1'b0; rready = 1'b1;
    n = 0; t = 0; first = -1; held = 1'b0; hd = 32'd0;
    while (n <= int'(len) && t < 200) begin
      #1;
      if (rvalid) begin
        if (first < 0) first = t;
        if (held) check("r_stall_hold", rdata, hd);
        if (rready) begin
          rd_data[n] = rdata; rd_last[n] = rlast; rd_resp[n] = rresp; rd_id = rid;
          n++; held = 1'b0;
        end else begin
          held = 1'b1; hd = rdata;
        end
      end
      @(posedge clk_i); @(negedge clk_i);
      t++;
      if (toggle) rready = ~rready;
    end
    rready = 1'b0;
    check("r_beat_count", n, int'(len) + 1);
    rd_first = first; rd_cycles = t;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    rst_i = 1'b0;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arburst = 0; rready = 0;

    // Reset state, with requests present that must not be accepted
    repeat (2) @(negedge clk_i);
    awvalid = 1'b1; arvalid = 1'b1; #1;
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bresp_bid", {bresp, bid}, 0);
    awvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;

    // INCR write then read-back
    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    axi_write(32'h9000_0010, 4'h5, 8'd3, 2'b01, 4'hF);
    check("incr_bid", b_id, 4'h5);
    check("incr_bresp", b_resp, 2'b00);
    axi_read(32'h9000_0010, 4'h9, 8'd3, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("incr_rdata%0d", i), rd_data[i], 32'h11 * (i + 1));
      check($sformatf("incr_rlast%0d", i), rd_last[i], i == 3);
    end
    check("incr_rid", rd_id, 4'h9);
    check("incr_rresp", rd_resp[0], 2'b00);
    check("incr_first_latency", rd_first, 2);

    // Byte strobes
    wbuf[0] = 32'h0;
    axi_write(32'h9000_0000, 4'h1, 8'd0, 2'b01, 4'hF);
    wbuf[0] = 32'hAABB_CCDD;
    axi_write(32'h9000_0000, 4'h1, 8'd0, 2'b01, 4'b0101);
    axi_read(32'h9000_0000, 4'h1, 8'd0, 2'b01, 1'b0);
    check("strb_rdata", rd_data[0], 32'h00BB_00DD);

    // Out-of-window access
    wbuf[0] = 32'hDEAD_BEEF;
    axi_write(32'h1000_0000, 4'h7, 8'd0, 2'b01, 4'hF);
    check("decerr_bresp", b_resp, 2'b11);
    axi_read(32'h9000_0000, 4'h1, 8'd0, 2'b01, 1'b0);
    check("decerr_ram_untouched", rd_data[0], 32'h00BB_00DD);
    axi_read(32'h1000_0000, 4'h6, 8'd0, 2'b01, 1'b0);
    check("decerr_rresp", rd_resp[0], 2'b11);
    check("decerr_rdata", rd_data[0], 32'h0);

    // Arbitration after a fresh reset; RAM survives reset
    @(negedge clk_i); rst_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i);
    awvalid = 1'b1; awaddr = 32'h9000_0040; awid = 4'h1; awlen = 8'd0; awburst = 2'b01;
    arvalid = 1'b1; araddr = 32'h9000_0010; arid = 4'h2; arlen = 8'd0; arburst = 2'b01;
    #1;
    check("prio1_awready", awready, 1);
    check("prio1_arready", arready, 0);
    @(posedge clk_i); @(negedge clk_i);
    awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wlast = 1'b1; bready = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    wvalid = 1'b0; wlast = 1'b0;
    awvalid = 1'b1; awaddr = 32'h9000_0044; awid = 4'h3;
    #1;
    check("prio_bvalid", bvalid, 1);
    check("prio_bid", bid, 4'h1);
    check("prio_no_aw_in_wresp", awready, 0);
    @(posedge clk_i); @(negedge clk_i);
    bready = 1'b0; #1;
    check("prio2_arready", arready, 1);
    check("prio2_awready", awready, 0);
    @(posedge clk_i); @(negedge clk_i);
    arvalid = 1'b0; rready = 1'b1;
    t = 0; #1;
    while (!rvalid && t < 10) begin @(negedge clk_i); #1; t++; end
    check("prio_rdata", rdata, 32'h11);
    check("prio_rid", rid, 4'h2);
    @(posedge clk_i); @(negedge clk_i);
    rready = 1'b0; #1;
    check("prio3_awready", awready, 1);
    @(posedge clk_i); @(negedge clk_i);
    awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h66; wlast = 1'b1; bready = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    wvalid = 1'b0; wlast = 1'b0; #1;
    check("prio3_bid", bid, 4'h3);
    @(posedge clk_i); @(negedge clk_i);
    bready = 1'b0;

    // 8-beat burst: rready toggling, then held high
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
    axi_write(32'h9000_0100, 4'h4, 8'd7, 2'b01, 4'hF);
    axi_read(32'h9000_0100, 4'hA, 8'd7, 2'b01, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tog_rdata%0d", i), rd_data[i], 32'hC0DE_0000 + 32'(i));
      check($sformatf("tog_rlast%0d", i), rd_last[i], i == 7);
    end
    axi_read(32'h9000_0100, 4'hB, 8'd7, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) check($sformatf("full_rdata%0d", i), rd_data[i], 32'hC0DE_0000 + 32'(i));
    check("full_first_latency", rd_first, 2);
    check("full_cycles", rd_cycles, 10);

    // Reset in the middle of a read burst
    @(negedge clk_i);
    arvalid = 1'b1; araddr = 32'h9000_0100; arid = 4'hC; arlen = 8'd7; arburst = 2'b01;
    @(posedge clk_i); @(negedge clk_i);
    arvalid = 1'b0; rready = 1'b1;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0; arvalid = 1'b1; #1;
    check("midrst_rvalid", rvalid, 0);
    check("midrst_rlast", rlast, 0);
    check("midrst_arready", arready, 0);
    arvalid = 1'b0; rready = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    axi_read(32'h9000_0104, 4'hD, 8'd1, 2'b01, 1'b0);
    check("after_rst_rdata0", rd_data[0], 32'hC0DE_0001);
    check("after_rst_rdata1", rd_data[1], 32'hC0DE_0002);

    // FIXED burst keeps one word
    wbuf[0] = 32'hA1; wbuf[1] = 32'hA2; wbuf[2] = 32'hA3;
    axi_write(32'h9000_0200, 4'h2, 8'd2, 2'b00, 4'hF);
    axi_read(32'h9000_0200, 4'h2, 8'd1, 2'b00, 1'b0);
    check("fixed_rdata0", rd_data[0], 32'hA3);
    check("fixed_rdata1", rd_data[1], 32'hA3);

    // Reserved burst code behaves as INCR
    axi_read(32'h9000_0100, 4'h3, 8'd1, 2'b11, 1'b0);
    check("rsvd_rdata1", rd_data[1], 32'hC0DE_0001);

    // INCR rolls over at the top of the window
    wbuf[0] = 32'hB1; wbuf[1] = 32'hB2;
    axi_write(32'h9000_3FFC, 4'h2, 8'd1, 2'b01, 4'hF);
    axi_read(32'h9000_0000, 4'h2, 8'd0, 2'b01, 1'b0);
    check("winwrap_word0", rd_data[0], 32'hB2);
    axi_read(32'h9000_3FFC, 4'h2, 8'd1, 2'b01, 1'b0);
    check("winwrap_rdata0", rd_data[0], 32'hB1);
    check("winwrap_rdata1", rd_data[1], 32'hB2);

`ifdef AXI4_RAM_TARGET_WRAP_EN
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hD0 + 32'(i);
    axi_write(32'h9000_0000, 4'h1, 8'd3, 2'b01, 4'hF);
    axi_read(32'h9000_0008, 4'h1, 8'd3, 2'b10, 1'b0);
    check("wrap_rdata0", rd_data[0], 32'hD2);
    check("wrap_rdata1", rd_data[1], 32'hD3);
    check("wrap_rdata2", rd_data[2], 32'hD0);
    check("wrap_rdata3", rd_data[3], 32'hD1);
    axi_read(32'h9000_0000, 4'h1, 8'd2, 2'b10, 1'b0);
    check("wrap_badlen_rresp", rd_resp[2], 2'b10);
    check("wrap_badlen_rdata", rd_data[1], 32'h0);
`else
    axi_read(32'h9000_0100, 4'h1, 8'd1, 2'b10, 1'b0);
    check("wrap_as_incr_rdata0", rd_data[0], 32'hC0DE_0000);
    check("wrap_as_incr_rdata1", rd_data[1], 32'hC0DE_0001);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
